pipe_scheduler: RTL and testbench
=================================

# pipe_scheduler

Game sequencer for the 16x16 LED flappy-bird game. Generates and scrolls the pipe field, detects bird/pipe collision, counts score, and emits the game-over flag. Sits between the bird-physics logic and the display mux: its `pipes` drives the display's green plane, and its `over` drives the display's game-over switch input.

## Interface
- `TICK_DIV`, 1000: clocks per scroll step (≥1).
- `SPACING`, 4: scroll steps between pipe spawns (≥2).
- `GAP`, 4: gap height in rows (1..15).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; one clock domain.
- `start`  in  1  start/restart request; level sampled each clock.
- `bird`  in  16  bird row mask for column `BIRD_COL` (= 4).
- `pipes`  out  [15:0][15:0]  pipe field; index = column, word = row mask.
- `step`  out  1  one-cycle pulse on each scroll step; used by bird physics.
- `over`  out  1  game over; level.
- `score`  out  8  pipes passed; saturating.

## Operation
- States:
  - IDLE: reset state.
  - RUN:
    - Enter from IDLE on `start`.
    - Exit to OVER on collision.
  - OVER:
    - On `start`, go to RUN.
    - On entry to RUN, clear `pipes`, `score` and both counters.
- `start` is ignored while in RUN.
- Tick counter, RUN only: counts 0..TICK_DIV-1. At TICK_DIV-1 it performs a step and wraps to 0.
- Spawn counter, RUN only: counts steps 0..SPACING-1. A new pipe is shifted in on steps where it reads 0, so the first step after start spawns.
- Step action:
  - `pipes[i] <= pipes[i+1]` for i = 0..14; column 0 is discarded.
  - `pipes[15] <=` new pipe word if spawning, else 0.
- Pipe word:
  - `~(((1<<GAP)-1) << gap_top)`.
  - `gap_top = min(lfsr[3:0], 16-GAP)`.
  - Result has exactly 16-GAP ones and GAP contiguous zeros.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1.
  - Advances every clock in every state, including IDLE, so start time randomizes the gaps.
  - Never reaches zero.
- Collision: `(pipes[BIRD_COL] & bird) != 0` while in RUN, evaluated combinationally on the current registers.
- Collision priority: on a cycle with a collision, any coinciding step is suppressed (no shift, no spawn, no score), and the next state is OVER.
- Score: on a step where `pipes[BIRD_COL] != 0` before the shift, `score` increments, saturating at 255.
- OVER: `pipes`, `score` and counters are frozen; `step` stays 0.
- Reset values:
  - State IDLE.
  - `pipes` = 0, `score` = 0, `over` = 0, `step` = 0.
  - Counters 0, LFSR = seed.
- Reset mid-operation: everything returns to reset values on the next edge; reset beats `start`.

## Timing
- All outputs are registered.
- `over` = 1 on the first clock in OVER, i.e. one cycle after the collision is visible on `pipes`/`bird`.
- `step` goes high in the same cycle the shifted `pipes` appear.
- Step cadence: the first `step` comes TICK_DIV clocks after the RUN-entry edge, then every TICK_DIV clocks.
- With TICK_DIV = 1 a step occurs every RUN clock; this must work.
- Spawned pipe position: a pipe spawned on step k reaches column 4 after step k+11 and leaves it on step k+12.

## Structure
- Shared package `game_pkg`:
  - `frame_t` (`logic [15:0][15:0]`).
  - `BIRD_COL` = 4.
  - `LFSR_SEED` = 16'hACE1.
  - State enum `game_state_t` {IDLE, RUN, OVER}.
- One sub-module `lfsr16`:
  - Ports: clk, reset, q[15:0].
  - Free-running, seeded on reset.
- Tick counter, spawn counter, FSM, shifter and score all live in `pipe_scheduler`.

## Test plan
All scenarios use TICK_DIV = 4, SPACING = 4, GAP = 4 unless stated.
- **Reset/idle:** assert reset, then idle 50 clocks with `start` = 0 -> `pipes` = 0, `score` = 0, `over` = 0, no `step` pulses.
- **Scroll and spawn:** pulse `start`, hold `bird` = 0 ->
  - `step` every 4 clocks.
  - After step 1, `pipes[15]` has exactly 12 ones and 4 contiguous zeros; after steps 2–4 the same word sits in column 14, 13, 12.
  - Second pipe appears in column 15 at step 5.
- **Score:** `bird` = 0 -> `score` = 1 after step 13 and 2 after step 17. With TICK_DIV = 1 over a long run, `score` saturates at 255 and does not wrap.
- **Collision:** `bird` = 16'hFFFF ->
  - `pipes[4]` goes nonzero after step 12.
  - `over` = 1 one clock later.
  - `pipes` and `score` (= 0) are frozen thereafter; no further `step`.
- **Restart and ignored start:**
  - `start` while in OVER -> next clock `pipes` = 0, `score` = 0, `over` = 0, and steps resume after 4 clocks.
  - `start` held in RUN has no effect on cadence.
- **Reset mid-RUN:** reset with `start` = 1 simultaneously -> IDLE with all outputs 0 on the next edge; LFSR reloads 16'hACE1, so the first gap after the next start matches the first run's gap for the same start timing.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the flappy-bird game blocks
package game_pkg;

    typedef logic [15:0][15:0] frame_t;

    localparam int          BIRD_COL  = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } game_state_t;

    // Pipe column: all rows lit except a run of `gap` rows starting at the clamped top.
    function automatic logic [15:0] pipe_word(input logic [3:0] rnd, input int gap);
        logic [15:0] ones;
        int          top;
        ones = 16'((32'd1 << gap) - 32'd1);
        top  = (int'(rnd) > 16 - gap) ? 16 - gap : int'(rnd);
        return ~(ones << top);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - pipe field scroller, collision detect, score and game-over FSM
module pipe_scheduler
    import game_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int SPACING  = 4,
    parameter int GAP      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        bird,
    output logic [15:0][15:0]  pipes,
    output logic               step,
    output logic               over,
    output logic [7:0]         score
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(SPACING);

    game_state_t   state;
    game_state_t   state_next;
    logic          enter_run;
    logic [TW-1:0] tick;
    logic [SW-1:0] spawn_cnt;
    logic [15:0]   rnd;
    logic          collide;
    logic          tick_wrap;
    logic          do_step;
    logic          spawn;
    logic          unused_rnd;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (rnd)
    );

    assign unused_rnd = ^rnd[15:4];

    assign collide   = (state == RUN) && ((pipes[BIRD_COL] & bird) != 16'h0);
    assign tick_wrap = (tick == TW'(TICK_DIV - 1));
    // A collision wins over a coinciding step: nothing moves on the fatal cycle.
    assign do_step   = (state == RUN) && !collide && tick_wrap;
    assign spawn     = (spawn_cnt == '0);

    always_comb begin
        state_next = state;
        enter_run  = 1'b0;
        case (state)
            IDLE, OVER: begin
                if (start) begin
                    state_next = RUN;
                    enter_run  = 1'b1;
                end
            end
            RUN: begin
                if (collide) begin
                    state_next = OVER;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pipes     <= '0;
            score     <= 8'd0;
            over      <= 1'b0;
            step      <= 1'b0;
            tick      <= '0;
            spawn_cnt <= '0;
        end else begin
            state <= state_next;
            over  <= (state_next == OVER);
            step  <= do_step;
            if (enter_run) begin
                pipes     <= '0;
                score     <= 8'd0;
                tick      <= '0;
                spawn_cnt <= '0;
            end else if ((state == RUN) && !collide) begin
                tick <= tick_wrap ? '0 : tick + 1'b1;
                if (do_step) begin
                    for (int i = 0; i < 15; i++) begin
                        pipes[i] <= pipes[i+1];
                    end
                    pipes[15] <= spawn ? pipe_word(rnd[3:0], GAP) : 16'h0;
                    spawn_cnt <= (spawn_cnt == SW'(SPACING - 1)) ? '0 : spawn_cnt + 1'b1;
                    if ((pipes[BIRD_COL] != 16'h0) && (score != 8'hFF)) begin
                        score <= score + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb/tb_pipe_scheduler.sv - randomized self-checking bench for pipe_scheduler
module tb_pipe_scheduler;
    import game_pkg::*;

    localparam int TD = 4;
    localparam int SP = 4;
    localparam int GP = 4;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] bird;
    frame_t      pipes;
    logic        step, over;
    logic [7:0]  score;

    logic        reset1, start1;
    logic [15:0] bird1;
    frame_t      pipes1;
    logic        step1, over1;
    logic [7:0]  score1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_step_seen = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    pipe_scheduler #(.TICK_DIV(TD), .SPACING(SP), .GAP(GP)) dut (
        .clk(clk), .reset(reset), .start(start), .bird(bird),
        .pipes(pipes), .step(step), .over(over), .score(score)
    );

    pipe_scheduler #(.TICK_DIV(1), .SPACING(SP), .GAP(GP)) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .bird(bird1),
        .pipes(pipes1), .step(step1), .over(over1), .score(score1)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: game state kept as plain values, steps derived from elapsed run clocks.
    int          m_state = 0;
    logic [15:0] m_lfsr  = LFSR_SEED;
    frame_t      m_pipes = '0;
    logic [7:0]  m_score = 8'd0;
    logic        m_over  = 1'b0;
    logic        m_step  = 1'b0;
    int          m_clks  = 0;
    int          m_steps = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [15:0] gap_word(input logic [15:0] x);
        int top;
        top = int'(x[3:0]);
        if (top > 16 - GP) top = 16 - GP;
        return ~(16'((1 << GP) - 1) << top);
    endfunction

    function automatic bit one_gap(input logic [15:0] w);
        logic [15:0] z;
        z = ~w;
        if (z == 16'h0) return 1'b0;
        while (!z[0]) z = z >> 1;
        return z == 16'((1 << GP) - 1);
    endfunction

    function automatic int sat_exp(input int m);
        int s;
        if (m < 13) return 0;
        s = (m - 13) / 4 + 1;
        return (s > 255) ? 255 : s;
    endfunction

    always @(posedge clk) begin : model
        bit collide, adv;
        if (reset) begin
            m_state = 0; m_lfsr = LFSR_SEED; m_pipes = '0; m_score = 0;
            m_over = 0; m_step = 0; m_clks = 0; m_steps = 0;
        end else begin
            collide = (m_state == 1) && ((m_pipes[BIRD_COL] & bird) != 16'h0);
            adv     = (m_state == 1) && !collide && (m_clks % TD == TD - 1);
            m_step  = adv;
            if (m_state != 1 && start) begin
                m_state = 1; m_pipes = '0; m_score = 0; m_clks = 0; m_steps = 0;
            end else if (m_state == 1) begin
                if (collide) begin
                    m_state = 2;
                end else begin
                    if (adv) begin
                        if (m_pipes[BIRD_COL] != 16'h0 && m_score < 8'd255) m_score++;
                        for (int i = 0; i < 15; i++) m_pipes[i] = m_pipes[i+1];
                        m_pipes[15] = (m_steps % SP == 0) ? gap_word(m_lfsr) : 16'h0;
                        m_steps++;
                    end
                    m_clks++;
                end
            end
            m_over = (m_state == 2);
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (step) n_step_seen++;
        if (cmp_en) begin
            chk("pipes", pipes, m_pipes);
            chk("score", 256'(score), 256'(m_score));
            chk("over", 256'(over), 256'(m_over));
            chk("step", 256'(step), 256'(m_step));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_step(input string tag, output int clks);
        clks = 0;
        do begin
            @(negedge clk);
            clks++;
        end while (!step && clks < 100);
        if (!step) chk(tag, 256'(0), 256'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c, s0, n;
        logic [15:0] w, g1;
        frame_t p;
        logic [7:0] sc;

        reset = 1; start = 0; bird = 0;
        reset1 = 1; start1 = 0; bird1 = 0;
        cyc(2);
        cmp_en = 1;
        reset = 0;

        s0 = n_step_seen;
        cyc(50);
        chk("idle_pipes", pipes, '0);
        chk("idle_score", 256'(score), 256'(0));
        chk("idle_over", 256'(over), 256'(0));
        chk("idle_steps", 256'(n_step_seen - s0), 256'(0));

        // start stays high for the whole run; it must not disturb cadence
        start = 1;
        cyc(1);
        wait_step("step1_timeout", c);
        chk("first_step_latency", 256'(c), 256'(TD));
        w = pipes[15];
        chk("spawn_ones", 256'($countones(w)), 256'(16 - GP));
        chk("spawn_contig", 256'(one_gap(w)), 256'(1));
        for (int k = 2; k <= 4; k++) begin
            wait_step("stepk_timeout", c);
            chk("cadence", 256'(c), 256'(TD));
            chk("scroll_col", 256'(pipes[16 - k]), 256'(w));
        end
        wait_step("step5_timeout", c);
        chk("second_spawn_ones", 256'($countones(pipes[15])), 256'(16 - GP));
        chk("first_pipe_col11", 256'(pipes[11]), 256'(w));
        for (int k = 6; k <= 13; k++) wait_step("run_timeout", c);
        chk("score_step13", 256'(score), 256'(1));
        for (int k = 14; k <= 17; k++) wait_step("run_timeout", c);
        chk("score_step17", 256'(score), 256'(2));
        start = 0;

        bird = 16'hFFFF;
        n = 0;
        while (!over && n < 200) begin cyc(1); n++; end
        chk("collide_mid_game", 256'(over), 256'(1));

        // restart from OVER, then fly straight into the first pipe
        start = 1;
        cyc(1);
        start = 0;
        chk("restart_pipes", pipes, '0);
        chk("restart_score", 256'(score), 256'(0));
        chk("restart_over", 256'(over), 256'(0));
        n = 0;
        c = 0;
        while (n < 12 && c < 100) begin
            cyc(1);
            c++;
            if (step) n++;
        end
        chk("col4_after_step12", 256'(pipes[BIRD_COL] != 16'h0), 256'(1));
        chk("over_not_yet", 256'(over), 256'(0));
        cyc(1);
        chk("over_next_clock", 256'(over), 256'(1));
        chk("collide_score", 256'(score), 256'(0));
        p = pipes; sc = score; s0 = n_step_seen;
        cyc(20);
        chk("frozen_pipes", pipes, p);
        chk("frozen_score", 256'(score), 256'(sc));
        chk("frozen_steps", 256'(n_step_seen - s0), 256'(0));

        // reset reseeds the LFSR: same start timing gives the same first gap
        bird = 0;
        reset = 1; cyc(1); reset = 0;
        cyc(7);
        start = 1; cyc(1); start = 0;
        wait_step("reseed1_timeout", c);
        g1 = pipes[15];
        cyc(30);
        reset = 1; start = 1;
        cyc(1);
        chk("rst_pipes", pipes, '0);
        chk("rst_score", 256'(score), 256'(0));
        chk("rst_over", 256'(over), 256'(0));
        chk("rst_step", 256'(step), 256'(0));
        reset = 0; start = 0;
        cyc(7);
        start = 1; cyc(1); start = 0;
        wait_step("reseed2_timeout", c);
        chk("reseed_gap", 256'(pipes[15]), 256'(g1));

        for (int g = 0; g < 8; g++) begin
            if ($urandom_range(3) == 0) begin reset = 1; cyc(1); reset = 0; end
            cyc($urandom_range(20));
            start = 1; cyc(1); start = 0;
            case ($urandom_range(2))
                0: bird = 16'h0;
                1: bird = 16'h1 << $urandom_range(15);
                default: bird = 16'($urandom);
            endcase
            for (int t = 0; t < 200; t++) begin
                start = ($urandom_range(15) == 0);
                if ($urandom_range(40) == 0) bird = 16'h1 << $urandom_range(15);
                if ($urandom_range(150) == 0) reset = 1; else reset = 0;
                cyc(1);
            end
            reset = 0;
            start = 0;
        end

        // single-clock step cadence, long run to score saturation
        reset1 = 0;
        cyc(1);
        start1 = 1; cyc(1); start1 = 0;
        for (int m = 1; m <= 1200; m++) begin
            cyc(1);
            if (m == 12 || m == 13 || m == 17 || m == 1029 || m == 1200 || m % 100 == 0)
                chk("sat_score", 256'(score1), 256'(sat_exp(m)));
        end
        chk("sat_over", 256'(over1), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
